// File: rtl/beamscaler_rd_pkg.sv
// Shared types and constants for the beam-scaler WISHBONE bank reader.
package beamscaler_rd_pkg;

  typedef enum logic [2:0] {IDLE, HDR, REQ, WAIT, PUSH} state_t;

  localparam logic [7:0]  HDR_MAGIC = 8'hB5;
  localparam logic [31:0] ERR_WORD  = 32'hDEAD_DEAD;

  // Word k maps to byte address {0, k[7], 0, k[6:0], 00}
  function automatic logic [11:0] word_addr(input logic [7:0] k);
    return {1'b0, k[7], 1'b0, k[6:0], 2'b00};
  endfunction

endpackage

// File: rtl/beamscaler_wb_reader.sv
// Drains one scaler bank over WISHBONE single reads and emits it as a framed
// 32-bit stream: header {B5, bank, seq} followed by NWORDS scaler words.
module beamscaler_wb_reader
  import beamscaler_rd_pkg::*;
#(
  parameter int unsigned NWORDS  = 48,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_i,
  input  logic        start_i,
  input  logic        bank_i,
  output logic        wb_cyc_o,
  output logic        wb_stb_o,
  output logic        wb_we_o,
  output logic [11:0] wb_adr_o,
  output logic [3:0]  wb_sel_o,
  output logic [31:0] wb_dat_o,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_ack_i,
  input  logic        wb_err_i,
  output logic [31:0] m_tdata,
  output logic        m_tvalid,
  input  logic        m_tready,
  output logic        m_tlast,
  output logic        busy_o,
  output logic        err_o,
  output logic [7:0]  miss_cnt_o
);

  localparam logic [7:0] LAST_K  = 8'(NWORDS - 1);
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT - 1);

  state_t      state;
  logic        cyc;
  logic [7:0]  k;
  logic [7:0]  tcnt;
  logic [15:0] seq;

  assign wb_cyc_o = cyc;
  assign wb_stb_o = cyc;
  assign wb_we_o  = 1'b0;
  assign wb_sel_o = 4'hF;
  assign wb_dat_o = '0;

  always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state      <= IDLE;
      cyc        <= 1'b0;
      wb_adr_o   <= '0;
      k          <= '0;
      tcnt       <= '0;
      seq        <= '0;
      m_tdata    <= '0;
      m_tvalid   <= 1'b0;
      m_tlast    <= 1'b0;
      busy_o     <= 1'b0;
      err_o      <= 1'b0;
      miss_cnt_o <= '0;
    end else begin
      if (start_i && state != IDLE && miss_cnt_o != 8'hFF)
        miss_cnt_o <= miss_cnt_o + 8'd1;

      case (state)
        IDLE: if (start_i) begin
          // Header is loaded on the start edge so valid follows start by one cycle
          m_tdata  <= {HDR_MAGIC, 7'd0, bank_i, seq};
          m_tvalid <= 1'b1;
          m_tlast  <= 1'b0;
          err_o    <= 1'b0;
          k        <= '0;
          busy_o   <= 1'b1;
          state    <= HDR;
        end
        HDR: if (m_tready) begin
          m_tvalid <= 1'b0;
          state    <= REQ;
        end
        REQ: begin
          cyc      <= 1'b1;
          wb_adr_o <= word_addr(k);
          tcnt     <= '0;
          state    <= WAIT;
        end
        WAIT: begin
          if (wb_err_i || wb_ack_i || tcnt == TO_LAST) begin
            cyc      <= 1'b0;
            m_tvalid <= 1'b1;
            m_tlast  <= (k == LAST_K);
            state    <= PUSH;
            if (wb_err_i || !wb_ack_i) begin
              m_tdata <= ERR_WORD;
              err_o   <= 1'b1;
            end else begin
              m_tdata <= wb_dat_i;
            end
          end else begin
            tcnt <= tcnt + 8'd1;
          end
        end
        PUSH: if (m_tready) begin
          m_tvalid <= 1'b0;
          m_tlast  <= 1'b0;
          if (k == LAST_K) begin
            seq    <= seq + 16'd1;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            k     <= k + 8'd1;
            state <= REQ;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_beamscaler_wb_reader.sv
// Self-checking bench: randomized WB target model plus frame-level reference.
module tb_beamscaler_wb_reader;

  localparam int NW = 200;
  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst;
  logic        start, bank;
  logic        cyc, stb, we;
  logic [11:0] adr;
  logic [3:0]  sel;
  logic [31:0] wdat, rdat;
  logic        ack, werr;
  logic [31:0] tdata;
  logic        tvalid, tready, tlast;
  logic        busy, err_o;
  logic [7:0]  miss;

  int n_checks = 0;
  int n_err    = 0;

  beamscaler_wb_reader #(.NWORDS(NW), .TIMEOUT(TO)) dut (
    .wb_clk_i(clk), .wb_rst_i(rst), .start_i(start), .bank_i(bank),
    .wb_cyc_o(cyc), .wb_stb_o(stb), .wb_we_o(we), .wb_adr_o(adr),
    .wb_sel_o(sel), .wb_dat_o(wdat), .wb_dat_i(rdat),
    .wb_ack_i(ack), .wb_err_i(werr),
    .m_tdata(tdata), .m_tvalid(tvalid), .m_tready(tready), .m_tlast(tlast),
    .busy_o(busy), .err_o(err_o), .miss_cnt_o(miss)
  );

  always #5 clk = ~clk;

  // ---------------- reference helpers ----------------
  logic [31:0] salt;
  int noack_k = 9999;
  int err_k   = 9999;
  logic rnd_ready = 1'b0;

  function automatic int addr_of(input int k);
    return (k < 128) ? k * 4 : 'h400 + (k - 128) * 4;
  endfunction

  function automatic int idx_of(input int a);
    return (a < 'h400) ? a / 4 : 128 + (a - 'h400) / 4;
  endfunction

  function automatic logic [31:0] data_of(input int a);
    return salt ^ (32'h9E37_79B9 * 32'(a + 1));
  endfunction

  // ---------------- WB target model: ack in 3rd cycle of stb ----------------
  int tcyc;
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ack <= 1'b0; werr <= 1'b0; rdat <= '0; tcyc <= 0;
    end else if (ack || werr) begin
      ack <= 1'b0; werr <= 1'b0; tcyc <= 0;
    end else if (cyc && stb) begin
      tcyc <= tcyc + 1;
      if (tcyc == 1 && idx_of(int'(adr)) != noack_k) begin
        ack  <= 1'b1;
        werr <= (idx_of(int'(adr)) == err_k);
        rdat <= data_of(int'(adr));
      end
    end else begin
      tcyc <= 0;
    end
  end

  always @(negedge clk) tready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;

  // ---------------- monitor ----------------
  logic clr = 1'b0;
  logic [31:0] beat_q[$];
  logic        last_q[$];
  int          rd_q[$];
  int prev_cyc, run, max_stb, stall_err;
  logic hold, hl;
  logic [31:0] hd;

  always @(posedge clk) begin
    if (clr || rst) begin
      beat_q.delete(); last_q.delete(); rd_q.delete();
      prev_cyc = 0; run = 0; max_stb = 0; stall_err = 0; hold = 1'b0;
    end else begin
      if (cyc && prev_cyc == 0) rd_q.push_back(int'(adr));
      if (cyc) run++;
      else begin
        if (prev_cyc != 0 && run > max_stb) max_stb = run;
        run = 0;
      end
      prev_cyc = int'(cyc);
      if (hold && (!tvalid || tdata !== hd || tlast !== hl)) stall_err++;
      if (tvalid && tready) begin
        beat_q.push_back(tdata);
        last_q.push_back(tlast);
      end
      hold = tvalid && !tready;
      hd = tdata;
      hl = tlast;
    end
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clear_mon();
    @(negedge clk) clr = 1'b1;
    @(negedge clk) clr = 1'b0;
  endtask

  logic [15:0] seq_m = '0;
  int          miss_m = 0;

  task automatic run_frame(input logic b, input int misses, input logic exp_err);
    int guard, bad_d, bad_l, bad_a;
    logic [31:0] exp;
    clear_mon();
    @(negedge clk) begin start = 1'b1; bank = b; end
    @(negedge clk) start = 1'b0;
    check("hdr_valid_latency", 32'(tvalid), 32'd1);
    check("hdr_tdata", tdata, {8'hB5, 7'd0, b, seq_m});
    check("err_cleared_on_start", 32'(err_o), 32'd0);
    check("busy_after_start", 32'(busy), 32'd1);
    for (int i = 0; i < misses; i++) begin
      repeat (10) @(negedge clk);
      start = 1'b1;
      @(negedge clk) start = 1'b0;
    end
    guard = 0;
    while (busy && guard < 6000) begin
      @(negedge clk);
      guard++;
    end
    check("frame_done_in_budget", 32'(guard < 6000), 32'd1);
    check("beat_count", 32'(beat_q.size()), 32'(NW + 1));
    check("rd_count", 32'(rd_q.size()), 32'(NW));
    if (beat_q.size() > 0) check("hdr_beat", beat_q[0], {8'hB5, 7'd0, b, seq_m});
    bad_d = 0; bad_l = 0; bad_a = 0;
    for (int k = 0; k < NW; k++) begin
      exp = (k == noack_k || k == err_k) ? 32'hDEAD_DEAD : data_of(addr_of(k));
      if (k + 1 >= beat_q.size() || beat_q[k + 1] !== exp) bad_d++;
      if (k >= rd_q.size() || rd_q[k] != addr_of(k)) bad_a++;
    end
    for (int i = 0; i < last_q.size(); i++)
      if (last_q[i] !== (i == NW)) bad_l++;
    check("data_beats", 32'(bad_d), 32'd0);
    check("read_addresses", 32'(bad_a), 32'd0);
    check("tlast_only_last", 32'(bad_l), 32'd0);
    check("addr_word128", 32'(rd_q.size() > 128 ? rd_q[128] : -1), 32'h400);
    check("addr_word199", 32'(rd_q.size() > 199 ? rd_q[199] : -1), 32'h51C);
    check("stall_stability", 32'(stall_err), 32'd0);
    check("stb_max_len", 32'(max_stb), (noack_k < NW) ? 32'(TO) : 32'd3);
    check("err_o", 32'(err_o), 32'(exp_err));
    miss_m = (miss_m + misses > 255) ? 255 : miss_m + misses;
    check("miss_cnt", 32'(miss), 32'(miss_m));
    check("busy_low_after_frame", 32'(busy), 32'd0);
    seq_m = seq_m + 16'd1;
  endtask

  initial begin
    int guard;
    salt  = $urandom;
    rst   = 1'b1;
    start = 1'b0;
    bank  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_cyc", 32'(cyc), 32'd0);
    check("rst_stb", 32'(stb), 32'd0);
    check("rst_tvalid", 32'(tvalid), 32'd0);
    check("rst_tdata", tdata, 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_err", 32'(err_o), 32'd0);
    check("rst_miss", 32'(miss), 32'd0);
    check("tie_we_sel_dat", {we, sel, wdat[26:0]}, {1'b0, 4'hF, 27'd0});
    rst = 1'b0;

    run_frame(1'b1, 0, 1'b0);

    rnd_ready = 1'b1;
    run_frame(1'($urandom_range(0, 1)), 0, 1'b0);

    rnd_ready = 1'b0;
    noack_k = 5;
    err_k   = 9;
    run_frame(1'b0, 0, 1'b1);
    noack_k = 9999;
    err_k   = 9999;

    rnd_ready = 1'b1;
    run_frame(1'b1, 3, 1'b0);
    repeat (20) @(negedge clk);
    check("no_extra_frame_valid", 32'(tvalid), 32'd0);
    check("no_extra_frame_beats", 32'(beat_q.size()), 32'(NW + 1));
    rnd_ready = 1'b0;

    // reset while a read is in flight
    @(negedge clk) begin start = 1'b1; bank = 1'b1; end
    @(negedge clk) start = 1'b0;
    guard = 0;
    while (!cyc && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    check("reached_wait", 32'(cyc), 32'd1);
    #1 rst = 1'b1;
    #1;
    check("async_rst_cyc", 32'(cyc), 32'd0);
    check("async_rst_stb", 32'(stb), 32'd0);
    check("async_rst_tvalid", 32'(tvalid), 32'd0);
    check("async_rst_miss", 32'(miss), 32'd0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    seq_m  = '0;
    miss_m = 0;
    run_frame(1'b0, 0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/beamscaler_wb_reader.md
# beamscaler_wb_reader

WISHBONE initiator that drains one complete scaler bank from the beam-scaler WISHBONE target and emits it as a framed 32-bit stream. It starts on the scaler block's bank-done pulse and reads every scaler word with single read cycles. Each completed frame carries a header word (bank, sequence number) followed by the scaler words. It sits in the WB clock domain between the scaler target and the housekeeping/event-readout path.

## Interface

Parameters
- NWORDS, 48: scaler words read per frame (1..256).
- TIMEOUT, 255: maximum cycles to wait for ack before aborting a word (1..255).

Ports
- wb_clk_i  in  1  the only clock.
- wb_rst_i  in  1  reset; asynchronous, active-high.
- start_i  in  1  single-cycle request to read a bank (the done pulse, already in the wb_clk_i domain).
- bank_i  in  1  bank index; sampled together with start_i.
- wb_cyc_o, wb_stb_o  out  1  WB cycle and strobe; always driven identically.
- wb_we_o  out  1  tied 0.
- wb_adr_o  out  12  byte address.
- wb_sel_o  out  4  tied 4'hF.
- wb_dat_o  out  32  tied 0.
- wb_dat_i  in  32  read data.
- wb_ack_i, wb_err_i  in  1  termination inputs.
- m_tdata  out  32  stream data.
- m_tvalid, m_tready, m_tlast  out/in/out  1  stream handshake.
- busy_o  out  1  high from accepted start until the last beat is accepted.
- err_o  out  1  sticky: a word in the current/last frame failed; cleared on accepted start.
- miss_cnt_o  out  8  count of starts dropped while busy; saturates at 255.

## Operation

- FSM states are IDLE, HDR, REQ, WAIT, PUSH.
- IDLE: when start_i is high, latch bank_i, clear err_o and the word index k to 0, and go to HDR.
- HDR: load m_tdata = {8'hB5, 7'd0, bank, 16'(seq)}, assert m_tvalid, and wait for m_tready. On the handshake go to REQ.
- REQ: drive cyc/stb high and wb_adr_o = {1'b0, k[7], 1'b0, k[6:0], 2'b00}, then go to WAIT. The timeout counter is cleared.
- WAIT: hold cyc/stb.
  - On wb_ack_i, capture wb_dat_i.
  - On wb_err_i or timeout expiry, load 32'hDEAD_DEAD and set err_o.
  - Any of these drops cyc/stb on the next edge and goes to PUSH.
  - If ack and err arrive together, err wins.
- PUSH: m_tvalid is high, and m_tlast = (k == NWORDS-1). On the handshake:
  - if this was the last word, increment seq (16-bit, wraps) and go to IDLE;
  - otherwise increment k and go to REQ.
- start_i while not in IDLE: drop it and increment miss_cnt_o (saturating).
- m_tdata and m_tlast are stable while m_tvalid is high and m_tready is low.

## Timing

- Reset values: all outputs 0; seq = 0, miss_cnt_o = 0, state IDLE.
- start_i to HDR m_tvalid: 1 cycle.
- Strobe handling:
  - cyc/stb rise on the edge entering WAIT.
  - They must fall on the edge after the one sampling ack, so stb is never high when the target returns to its idle state. This rule prevents a duplicate read.
- Per word against the 3-cycle target, with m_tready held high: REQ 1 + target latency 3 + PUSH 1 = 5 cycles.
- Full frame: (NWORDS+1) beats; about 5*NWORDS + 2 cycles.
- Timeout fires when the counter reaches TIMEOUT with no ack/err. Abort occurs TIMEOUT cycles after stb rises.
- Reset mid-cycle: cyc/stb drop immediately (asynchronously), m_tvalid drops, and the partial frame is discarded without a tlast.

## Structure

- Package beamscaler_rd_pkg holds:
  - the state enum;
  - HDR_MAGIC = 8'hB5;
  - ERR_WORD = 32'hDEAD_DEAD;
  - a function mapping word index to the 12-bit address (bit 10 = k[7], bits 8:2 = k[6:0], bits 11, 9, 1:0 = 0).
- No sub-module; a single FSM with an output register.

## Test plan

- Reset, then a start_i pulse with bank_i=1 against a 3-cycle-ack target model with m_tready=1. Required response:
  - header 32'hB501_0000;
  - 48 data words matching the model, at addresses 0x000, 0x004, … 0x0BC;
  - tlast only on beat 49;
  - busy_o low after beat 49.
- NWORDS=200: word 128 must be read at address 0x400, and word 199 at 0x51C.
- m_tready toggled randomly 50%: no lost or duplicated beats, data stable while stalled, and exactly one WB read per address (the model counts reads).
- Target never acks word 5 (TIMEOUT=255):
  - stb drops 255 cycles after rising;
  - beat 7 = 32'hDEAD_DEAD and err_o=1;
  - words 6+ are still read normally;
  - next start clears err_o.
- Three start_i pulses during one frame: miss_cnt_o=3 and only one frame emitted. A second frame's header has seq=1; after 65536 frames, seq wraps to 0.
- wb_rst_i asserted in WAIT: cyc/stb/m_tvalid go 0 before the next edge. After release a new start yields a clean frame with seq=0.
